// File: rtl/display_pkg.sv
// Shared constants for the seven-segment pattern displayer: glyphs, animation modes, dwell limit.
package display_pkg;

    localparam logic [7:0] GLYPH_UP   = 8'h39;
    localparam logic [7:0] GLYPH_DOWN = 8'hC5;
    localparam logic [7:0] GLYPH_OFF  = 8'hFF;

    localparam int DWELL_MAX = 15;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        SCROLL = 2'd1,
        BLINK  = 2'd2,
        FILL   = 2'd3
    } mode_t;

endpackage

// File: rtl/display_sequencer_dwell_timer.sv
// Dwell counter: divides clk_1HZ into animation steps; tick marks each unpaused step boundary.
module dwell_timer
    import display_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk_1HZ,
    input  logic rst,
    input  logic pause,
    output logic tick
);

    localparam logic [3:0] LAST = 4'(DWELL - 1);

    logic [3:0] count;

    assign tick = !pause && (count == LAST);

    // pause holds the count so a resumed dwell finishes exactly where it stopped
    always_ff @(posedge clk_1HZ) begin
        if (rst)
            count <= 4'd0;
        else if (tick)
            count <= 4'd0;
        else if (!pause)
            count <= count + 4'd1;
    end

endmodule

// File: rtl/display_sequencer.sv
// Four-digit pattern scheduler (BOUNCE/SCROLL/BLINK/FILL) with pause, dwell and mirroring.
// BLINK is only built when DISPLAY_SEQ_BLINK_EN is defined; otherwise mode 2 behaves as BOUNCE.
module display_sequencer
    import display_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic       clk_1HZ,
    input  logic       rst,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic       mirror,
    output logic [7:0] digit0,
    output logic [7:0] digit1,
    output logic [7:0] digit2,
    output logic [7:0] digit3,
    output logic [1:0] pos,
    output logic       dir,
    output logic       step
);

    logic       tick;
    mode_t      mode_q, mode_n, req_mode;
    logic [1:0] pos_n;
    logic       dir_n;
    logic [2:0] fill, fill_n, fill_inc;
    logic [7:0] logical [4];
`ifdef DISPLAY_SEQ_BLINK_EN
    logic       phase, phase_n;
`endif

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk_1HZ (clk_1HZ),
        .rst     (rst),
        .pause   (pause),
        .tick    (tick)
    );

    always_ff @(posedge clk_1HZ) begin
        if (rst) begin
            mode_q <= BOUNCE;
            pos    <= 2'd0;
            dir    <= 1'b0;
            fill   <= 3'd0;
            step   <= 1'b0;
`ifdef DISPLAY_SEQ_BLINK_EN
            phase  <= 1'b0;
`endif
        end else begin
            mode_q <= mode_n;
            pos    <= pos_n;
            dir    <= dir_n;
            fill   <= fill_n;
            step   <= tick;
`ifdef DISPLAY_SEQ_BLINK_EN
            phase  <= phase_n;
`endif
        end
    end

    // Next-state: a mode change is only taken at a step boundary and replaces that step's advance
    always_comb begin
        req_mode = mode_t'(mode);
`ifndef DISPLAY_SEQ_BLINK_EN
        if (req_mode == BLINK)
            req_mode = BOUNCE;
`endif
        mode_n   = mode_q;
        pos_n    = pos;
        dir_n    = dir;
        fill_n   = fill;
        fill_inc = (fill == 3'd4) ? 3'd0 : fill + 3'd1;
`ifdef DISPLAY_SEQ_BLINK_EN
        phase_n  = phase;
`endif
        if (tick) begin
            if (req_mode != mode_q) begin
                mode_n = req_mode;
                pos_n  = 2'd0;
                dir_n  = 1'b0;
                fill_n = 3'd0;
`ifdef DISPLAY_SEQ_BLINK_EN
                phase_n = 1'b0;
`endif
            end else begin
                case (mode_q)
                    BOUNCE: begin
                        if (!dir) begin
                            if (pos == 2'd3) dir_n = 1'b1;
                            else             pos_n = pos + 2'd1;
                        end else begin
                            if (pos == 2'd0) dir_n = 1'b0;
                            else             pos_n = pos - 2'd1;
                        end
                    end
                    SCROLL: pos_n = pos + 2'd1;
`ifdef DISPLAY_SEQ_BLINK_EN
                    BLINK:  phase_n = !phase;
`endif
                    FILL: begin
                        fill_n = fill_inc;
                        pos_n  = (fill_inc == 3'd4) ? 2'd3 : fill_inc[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            logical[i] = GLYPH_OFF;
        case (mode_q)
            BOUNCE: logical[pos] = dir ? GLYPH_DOWN : GLYPH_UP;
            SCROLL: logical[pos] = GLYPH_UP;
`ifdef DISPLAY_SEQ_BLINK_EN
            BLINK: begin
                for (int i = 0; i < 4; i++)
                    logical[i] = phase ? GLYPH_UP : GLYPH_OFF;
            end
`endif
            FILL: begin
                for (int i = 0; i < 4; i++)
                    logical[i] = (3'(i) < fill) ? GLYPH_UP : GLYPH_OFF;
            end
            default: ;
        endcase
    end

    assign digit0 = mirror ? logical[3] : logical[0];
    assign digit1 = mirror ? logical[2] : logical[1];
    assign digit2 = mirror ? logical[1] : logical[2];
    assign digit3 = mirror ? logical[0] : logical[3];

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized self-checking bench for display_sequencer (DWELL = 1 and DWELL = 3 side by side).
module tb_display_sequencer;
    import display_pkg::*;

    logic       clk_1HZ = 1'b0;
    logic       rst, pause, mirror;
    logic [1:0] mode;

    logic [7:0] obs_dig [2][4];
    logic [1:0] obs_pos [2];
    logic       obs_dir [2];
    logic       obs_step[2];

    int checks = 0;
    int errors = 0;

    // model state: dwell count, current mode, steps since last reload, expected step pulse
    int m_cnt[2];
    int m_mq [2];
    int m_k  [2];
    int m_stp[2];
    int dwell_of[2] = '{1, 3};

    always #5 clk_1HZ = ~clk_1HZ;

    display_sequencer #(.DWELL(1)) dut1 (
        .clk_1HZ(clk_1HZ), .rst(rst), .pause(pause), .mode(mode), .mirror(mirror),
        .digit0(obs_dig[0][0]), .digit1(obs_dig[0][1]), .digit2(obs_dig[0][2]), .digit3(obs_dig[0][3]),
        .pos(obs_pos[0]), .dir(obs_dir[0]), .step(obs_step[0])
    );

    display_sequencer #(.DWELL(3)) dut3 (
        .clk_1HZ(clk_1HZ), .rst(rst), .pause(pause), .mode(mode), .mirror(mirror),
        .digit0(obs_dig[1][0]), .digit1(obs_dig[1][1]), .digit2(obs_dig[1][2]), .digit3(obs_dig[1][3]),
        .pos(obs_pos[1]), .dir(obs_dir[1]), .step(obs_step[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic [1:0] m, input logic mir);
        rst    = r;
        pause  = p;
        mode   = m;
        mirror = mir;
    endtask

    // BOUNCE walks 0,1,2,3,3,2,1,0 over an 8-step period; dir is 1 in the second half
    function automatic int expPos(int u);
        int k = m_k[u];
        case (m_mq[u])
            0: expPos = ((k % 8) < 4) ? (k % 8) : 7 - (k % 8);
            1: expPos = k % 4;
            3: expPos = ((k % 5) == 4) ? 3 : (k % 5);
            default: expPos = 0;
        endcase
    endfunction

    function automatic int expDir(int u);
        expDir = (m_mq[u] == 0 && (m_k[u] % 8) >= 4) ? 1 : 0;
    endfunction

    function automatic logic [31:0] expDigits(int u, logic mir);
        logic [7:0]  lg[4];
        logic [31:0] w;
        for (int i = 0; i < 4; i++) lg[i] = GLYPH_OFF;
        case (m_mq[u])
            0: lg[expPos(u)] = (expDir(u) == 1) ? GLYPH_DOWN : GLYPH_UP;
            1: lg[expPos(u)] = GLYPH_UP;
            3: for (int i = 0; i < 4; i++) if (i < (m_k[u] % 5)) lg[i] = GLYPH_UP;
            default: ;
        endcase
        w = '0;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = lg[mir ? 3 - k : k];
        return w;
    endfunction

    task automatic modelStep();
        int em;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_cnt[u] = 0; m_mq[u] = 0; m_k[u] = 0; m_stp[u] = 0;
            end else if (pause) begin
                m_stp[u] = 0;
            end else if (m_cnt[u] == dwell_of[u] - 1) begin
                m_cnt[u] = 0;
                m_stp[u] = 1;
                em = (mode == 2'd2) ? 0 : int'(mode);
                if (em != m_mq[u]) begin
                    m_mq[u] = em;
                    m_k[u]  = 0;
                end else begin
                    m_k[u] = (m_k[u] + 1) % 40;
                end
            end else begin
                m_cnt[u]++;
                m_stp[u] = 0;
            end
        end
    endtask

    function automatic logic [31:0] obsDigits(int u);
        return {obs_dig[u][3], obs_dig[u][2], obs_dig[u][1], obs_dig[u][0]};
    endfunction

    task automatic checkAll(input string ph);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("%s u%0d pos", ph, u), 32'(obs_pos[u]), 32'(expPos(u)));
            checkOutput($sformatf("%s u%0d dir", ph, u), 32'(obs_dir[u]), 32'(expDir(u)));
            checkOutput($sformatf("%s u%0d step", ph, u), 32'(obs_step[u]), 32'(m_stp[u]));
            checkOutput($sformatf("%s u%0d digits", ph, u), obsDigits(u), expDigits(u, mirror));
        end
    endtask

    task automatic runCycle(input logic r, input logic p, input logic [1:0] m, input logic mir, input string ph);
        applyStimulus(r, p, m, mir);
        @(posedge clk_1HZ);
        modelStep();
        #1;
        checkAll(ph);
        @(negedge clk_1HZ);
    endtask

    int bounce_pos[8] = '{1, 2, 3, 3, 2, 1, 0, 0};
    int bounce_dir[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        logic [1:0] cur_mode;
        logic       cur_mir;
        for (int u = 0; u < 2; u++) begin
            m_cnt[u] = 0; m_mq[u] = 0; m_k[u] = 0; m_stp[u] = 0;
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk_1HZ);
        runCycle(1'b1, 1'b0, 2'd0, 1'b0, "reset");
        checkOutput("reset digits const", obsDigits(0), {GLYPH_OFF, GLYPH_OFF, GLYPH_OFF, GLYPH_UP});

        // explicit BOUNCE walk against the fixed reference sequence
        for (int s = 0; s < 8; s++) begin
            runCycle(1'b0, 1'b0, 2'd0, 1'b0, "bounce");
            checkOutput($sformatf("bounce table pos s%0d", s), 32'(obs_pos[0]), 32'(bounce_pos[s]));
            checkOutput($sformatf("bounce table dir s%0d", s), 32'(obs_dir[0]), 32'(bounce_dir[s]));
        end

        // pause window, then FILL switch, then mode 2 (folds to BOUNCE in the default build)
        for (int s = 0; s < 2; s++) runCycle(1'b0, 1'b0, 2'd0, 1'b0, "pre-pause");
        for (int s = 0; s < 5; s++) runCycle(1'b0, 1'b1, 2'd0, 1'b0, "pause");
        for (int s = 0; s < 18; s++) runCycle(1'b0, 1'b0, 2'd3, 1'b0, "fill");
        for (int s = 0; s < 18; s++) runCycle(1'b0, 1'b0, 2'd2, 1'b1, "mode2");

        cur_mode = 2'd1;
        cur_mir  = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 24) == 0) cur_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  cur_mir  = ~cur_mir;
            runCycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), cur_mode, cur_mir, "rand");
            if (n % 10 == 0) begin
                mirror = ~mirror;
                #1;
                for (int u = 0; u < 2; u++)
                    checkOutput($sformatf("mirror flip u%0d", u), obsDigits(u), expDigits(u, mirror));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
